keyboard_note_decoder: RTL and testbench

- Converts PS/2 set-2 scan-code bytes from the keyboard receiver into the 7-bit `keyboard_note` consumed by the game controller.
- Tracks press and release (F0 break prefix) and skips E0 extended codes.
- Keeps a last-pressed-wins stack of held note keys and applies a saturating octave shift (Z/X keys).
- Output is 0 when no note key is held. 7'h7F is never produced because it is reserved as the song-finish marker.

---
 rtl/keyboard_note_decoder_pkg.sv | 20 ++
 rtl/keyboard_note_decoder_if.sv | 27 ++
 rtl/keyboard_note_decoder_scan_to_semitone.sv | 31 +++
 rtl/keyboard_note_decoder.sv | 156 +++++++++++++++
 tb/tb_keyboard_note_decoder.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keyboard_note_decoder_pkg.sv
// Shared constants and types for the keyboard note decoder.
// Scan-code markers, note sentinels and prefix FSM states.
package note_pkg;

  localparam logic [6:0] NOTE_NONE   = 7'd0;
  localparam logic [6:0] NOTE_FINISH = 7'h7F;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_Z  = 8'h1A;
  localparam logic [7:0] SC_X  = 8'h22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } pfx_e;

endpackage

// File: rtl/keyboard_note_decoder_if.sv
// Scan-byte input and note output bundle.
// master drives scan bytes, slave is the decoder.
interface keyboard_note_decoder_if;

  logic [7:0] scan_code;
  logic       scan_valid;
  logic [6:0] keyboard_note;
  logic       key_down;
  logic [2:0] octave_out;

  modport master (
    output scan_code,
    output scan_valid,
    input  keyboard_note,
    input  key_down,
    input  octave_out
  );

  modport slave (
    input  scan_code,
    input  scan_valid,
    output keyboard_note,
    output key_down,
    output octave_out
  );

endinterface

// File: rtl/keyboard_note_decoder_scan_to_semitone.sv
// Maps a set-2 scan code onto a semitone of the octave.
// hit_o is low for codes that are not note keys.
module scan_to_semitone (
  input  logic [7:0] code_i,
  output logic       hit_o,
  output logic [3:0] semi_o
);

  // Fixed piano-row key map
  always_comb begin
    hit_o  = 1'b1;
    semi_o = 4'd0;
    case (code_i)
      8'h1C:   semi_o = 4'd0;
      8'h1D:   semi_o = 4'd1;
      8'h1B:   semi_o = 4'd2;
      8'h24:   semi_o = 4'd3;
      8'h23:   semi_o = 4'd4;
      8'h2B:   semi_o = 4'd5;
      8'h2C:   semi_o = 4'd6;
      8'h34:   semi_o = 4'd7;
      8'h35:   semi_o = 4'd8;
      8'h33:   semi_o = 4'd9;
      8'h3C:   semi_o = 4'd10;
      8'h3B:   semi_o = 4'd11;
      8'h42:   semi_o = 4'd12;
      default: hit_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/keyboard_note_decoder.sv
// PS/2 set-2 byte stream to MIDI note for the game controller.
// Last-pressed-wins key stack plus saturating octave shift.
module keyboard_note_decoder
  import note_pkg::*;
#(
  parameter logic [6:0] BASE_NOTE   = 7'd60,
  parameter int         STACK_DEPTH = 4,
  parameter int         OCT_MIN     = -2,
  parameter int         OCT_MAX     = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in_n,
  keyboard_note_decoder_if.slave  bus
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam logic signed [2:0] OMIN = 3'(OCT_MIN);
  localparam logic signed [2:0] OMAX = 3'(OCT_MAX);

  pfx_e              state_q, state_d;
  logic [3:0]        stk_q [STACK_DEPTH];
  logic [3:0]        stk_d [STACK_DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic signed [2:0] oct_q, oct_d;
  logic              z_q, z_d;
  logic              x_q, x_d;
  logic [6:0]        note_q, note_d;
  logic              kd_q, kd_d;

  logic              hit;
  logic [3:0]        semi;
  logic              is_make, is_brk;
  logic              found;
  int                idx;
  logic [3:0]        top;
  logic signed [8:0] base9, oct9, sum;

  scan_to_semitone u_map (
    .code_i (bus.scan_code),
    .hit_o  (hit),
    .semi_o (semi)
  );

  // Prefix tracking; classify the current byte as make or break
  always_comb begin
    state_d = state_q;
    is_make = 1'b0;
    is_brk  = 1'b0;
    if (bus.scan_valid) begin
      if (bus.scan_code == SC_E0) begin
        state_d = ST_EXT;
      end else if (bus.scan_code == SC_F0) begin
        state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
      end else begin
        state_d = ST_IDLE;
        is_make = (state_q == ST_IDLE);
        is_brk  = (state_q == ST_BRK);
      end
    end
  end

  // Held-key stack and octave update
  always_comb begin
    stk_d = stk_q;
    cnt_d = cnt_q;
    oct_d = oct_q;
    z_d   = z_q;
    x_d   = x_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (CW'(i) < cnt_q && stk_q[i] == semi) begin
        found = 1'b1;
        idx   = i;
      end
    end
    if (is_make && hit && !found) begin
      if (cnt_q == CW'(STACK_DEPTH)) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) begin
          stk_d[i] = stk_q[i+1];
        end
        stk_d[STACK_DEPTH-1] = semi;
      end else begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (CW'(i) == cnt_q) stk_d[i] = semi;
        end
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (is_brk && hit && found) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) begin
        if (i >= idx) stk_d[i] = stk_q[i+1];
      end
      cnt_d = cnt_q - 1'b1;
    end
    if (is_make && bus.scan_code == SC_Z && !z_q) begin
      z_d = 1'b1;
      if (oct_q > OMIN) oct_d = oct_q - 3'sd1;
    end
    if (is_make && bus.scan_code == SC_X && !x_q) begin
      x_d = 1'b1;
      if (oct_q < OMAX) oct_d = oct_q + 3'sd1;
    end
    if (is_brk && bus.scan_code == SC_Z) z_d = 1'b0;
    if (is_brk && bus.scan_code == SC_X) x_d = 1'b0;
  end

  // Note from top of stack and octave, clamped off 0 and 7F
  always_comb begin
    top = 4'd0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (CW'(i + 1) == cnt_d) top = stk_d[i];
    end
    base9 = $signed({2'b00, BASE_NOTE});
    oct9  = {{6{oct_d[2]}}, oct_d};
    sum   = base9 + oct9 * 9'sd12 + $signed({5'b00000, top});
    if (cnt_d == '0) begin
      note_d = NOTE_NONE;
    end else if (sum < 9'sd1) begin
      note_d = 7'd1;
    end else if (sum > 9'sd126) begin
      note_d = 7'd126;
    end else begin
      note_d = sum[6:0];
    end
    kd_d = (cnt_d != '0);
  end

  // State and registered outputs
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= 4'd0;
      cnt_q   <= '0;
      oct_q   <= 3'sd0;
      z_q     <= 1'b0;
      x_q     <= 1'b0;
      note_q  <= NOTE_NONE;
      kd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      stk_q   <= stk_d;
      cnt_q   <= cnt_d;
      oct_q   <= oct_d;
      z_q     <= z_d;
      x_q     <= x_d;
      note_q  <= note_d;
      kd_q    <= kd_d;
    end
  end

  assign bus.keyboard_note = note_q;
  assign bus.key_down      = kd_q;
  assign bus.octave_out    = oct_q;

endmodule

// File: tb/tb_keyboard_note_decoder.sv
// Bench for keyboard_note_decoder: directed plan plus random bytes.
// Reference model keeps held keys as a queue and octave as an int.
module tb_keyboard_note_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  keyboard_note_decoder_if bus ();

  keyboard_note_decoder #(
    .BASE_NOTE   (7'd60),
    .STACK_DEPTH (4),
    .OCT_MIN     (-2),
    .OCT_MAX     (2)
  ) dut (
    .clk_in   (clk),
    .rst_in_n (rst_n),
    .bus      (bus)
  );

  typedef struct packed {
    logic [6:0] note;
    logic       kd;
    logic [2:0] oct;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q [$];

  int   semi_of [int];
  int   held [$];
  int   m_oct;
  bit   m_z, m_x, m_ext, m_brk;

  logic [7:0] note_codes [13] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
                                  8'h33, 8'h3B, 8'h42, 8'h1D, 8'h24,
                                  8'h2C, 8'h35, 8'h3C};

  function automatic void model_reset();
    held.delete();
    m_oct = 0;
    m_z = 0; m_x = 0; m_ext = 0; m_brk = 0;
  endfunction

  function automatic int held_pos(int s);
    for (int i = 0; i < held.size(); i++) if (held[i] == s) return i;
    return -1;
  endfunction

  function automatic void do_make(int b);
    if (semi_of.exists(b)) begin
      if (held_pos(semi_of[b]) < 0) begin
        if (held.size() == 4) void'(held.pop_front());
        held.push_back(semi_of[b]);
      end
    end else if (b == 'h1A && !m_z) begin
      m_z = 1;
      if (m_oct > -2) m_oct--;
    end else if (b == 'h22 && !m_x) begin
      m_x = 1;
      if (m_oct < 2) m_oct++;
    end
  endfunction

  function automatic void do_break(int b);
    int p;
    if (semi_of.exists(b)) begin
      p = held_pos(semi_of[b]);
      if (p >= 0) held.delete(p);
    end else if (b == 'h1A) m_z = 0;
    else if (b == 'h22) m_x = 0;
  endfunction

  function automatic void model_byte(logic [7:0] b);
    if (b == 8'hE0) begin
      m_ext = 1; m_brk = 0;
    end else if (b == 8'hF0) begin
      m_ext = m_ext && !m_brk;
      m_brk = 1;
    end else begin
      if (!m_ext) begin
        if (m_brk) do_break(int'(b));
        else do_make(int'(b));
      end
      m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   n;
    e.oct = 3'(m_oct);
    if (held.size() == 0) begin
      e.note = 7'd0;
      e.kd   = 1'b0;
    end else begin
      n = 60 + 12 * m_oct + held[held.size()-1];
      if (n < 1) n = 1;
      if (n > 126) n = 126;
      e.note = 7'(n);
      e.kd   = 1'b1;
    end
    return e;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.scan_code  = b;
    bus.scan_valid = 1'b1;
    model_byte(b);
    exp_q.push_back(model_out());
    @(negedge clk);
    bus.scan_valid = 1'b0;
  endtask

  task automatic chk(input string nm, input int en, input int ekd,
                     input int eoct);
    tests++;
    if (bus.keyboard_note !== 7'(en) || bus.key_down !== 1'(ekd) ||
        bus.octave_out !== 3'(eoct)) begin
      fails++;
      $display("FAIL %s: got note=%0d kd=%0d oct=%0d, want note=%0d kd=%0d oct=%0d",
               nm, bus.keyboard_note, bus.key_down,
               $signed(bus.octave_out), en, ekd, eoct);
    end
  endtask

  task automatic sc(input logic [7:0] b, input string nm, input int en,
                    input int ekd, input int eoct);
    send(b);
    chk(nm, en, ekd, eoct);
  endtask

  // Monitor: every accepted byte produces one scoreboard comparison
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus.scan_valid === 1'b1 && rst_n === 1'b1) begin
        @(negedge clk);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard: output with no expected entry");
        end else begin
          e = exp_q.pop_front();
          if (bus.keyboard_note !== e.note || bus.key_down !== e.kd ||
              bus.octave_out !== e.oct) begin
            fails++;
            $display("FAIL scoreboard: got note=%0d kd=%0d oct=%0d, want note=%0d kd=%0d oct=%0d",
                     bus.keyboard_note, bus.key_down,
                     $signed(bus.octave_out), e.note, e.kd,
                     $signed(e.oct));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    semi_of['h1C] = 0;  semi_of['h1D] = 1;  semi_of['h1B] = 2;
    semi_of['h24] = 3;  semi_of['h23] = 4;  semi_of['h2B] = 5;
    semi_of['h2C] = 6;  semi_of['h34] = 7;  semi_of['h35] = 8;
    semi_of['h33] = 9;  semi_of['h3C] = 10; semi_of['h3B] = 11;
    semi_of['h42] = 12;
    model_reset();
    bus.scan_code  = 8'h00;
    bus.scan_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    sc(8'h1C, "a_make", 60, 1, 0);
    sc(8'hF0, "a_brk_pfx", 60, 1, 0);
    sc(8'h1C, "a_brk", 0, 0, 0);

    sc(8'h1C, "adh_a", 60, 1, 0);
    sc(8'h23, "adh_d", 64, 1, 0);
    sc(8'h33, "adh_h", 69, 1, 0);
    sc(8'hF0, "adh_pfx1", 69, 1, 0);
    sc(8'h23, "adh_rel_d", 69, 1, 0);
    sc(8'hF0, "adh_pfx2", 69, 1, 0);
    sc(8'h33, "adh_rel_h", 60, 1, 0);
    sc(8'hF0, "adh_pfx3", 60, 1, 0);
    sc(8'h1C, "adh_rel_a", 0, 0, 0);

    sc(8'h1C, "full_a", 60, 1, 0);
    sc(8'h1B, "full_s", 62, 1, 0);
    sc(8'h23, "full_d", 64, 1, 0);
    sc(8'h2B, "full_f", 65, 1, 0);
    sc(8'h34, "full_g", 67, 1, 0);
    send(8'hF0);
    sc(8'h34, "full_rel_g", 65, 1, 0);
    send(8'hF0);
    sc(8'h2B, "full_rel_f", 64, 1, 0);
    send(8'hF0);
    sc(8'h23, "full_rel_d", 62, 1, 0);
    send(8'hF0);
    sc(8'h1B, "full_rel_s", 0, 0, 0);

    sc(8'h42, "k_make", 72, 1, 0);
    sc(8'h22, "x_up", 84, 1, 1);
    sc(8'h22, "x_repeat", 84, 1, 1);
    send(8'hF0);
    sc(8'h22, "x_rel", 84, 1, 1);
    sc(8'h22, "x_up2", 96, 1, 2);
    send(8'hF0);
    send(8'h22);
    sc(8'h22, "x_saturate", 96, 1, 2);
    sc(8'h1A, "z_down", 84, 1, 1);
    send(8'hF0);
    sc(8'h42, "k_rel", 0, 0, 1);
    send(8'hF0);
    send(8'h1A);
    send(8'hF0);
    send(8'h22);
    sc(8'h1A, "z_down2", 0, 0, 0);
    send(8'hF0);
    sc(8'h1A, "z_rel", 0, 0, 0);

    send(8'hE0);
    sc(8'h1C, "ext_make", 0, 0, 0);
    send(8'hE0);
    send(8'hF0);
    sc(8'h1C, "ext_brk", 0, 0, 0);
    sc(8'h5A, "unmapped", 0, 0, 0);
    sc(8'h1C, "typ1", 60, 1, 0);
    sc(8'h1C, "typ2", 60, 1, 0);
    sc(8'h1C, "typ3", 60, 1, 0);
    send(8'hF0);
    sc(8'h1C, "typ_rel", 0, 0, 0);

    sc(8'h1C, "pre_rst_a", 60, 1, 0);
    sc(8'hE0, "pre_rst_e0", 60, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sc(8'h1C, "post_rst_a", 60, 1, 0);

    repeat (600) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 40) send(note_codes[$urandom_range(0, 12)]);
      else if (r < 55) begin
        send(8'hF0);
        if ($urandom_range(0, 1) == 0) send(note_codes[$urandom_range(0, 12)]);
        else send($urandom_range(0, 1) == 0 ? 8'h1A : 8'h22);
      end
      else if (r < 62) send(8'hE0);
      else if (r < 70) send(8'h1A);
      else if (r < 78) send(8'h22);
      else if (r < 82) send(8'hF0);
      else if (r < 86) send(8'h5A);
      else send(8'($urandom_range(0, 255)));
    end

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
